// File: rtl/note_hit_judge.sv
// note_hit_judge: player-input end of the falling-note display.
// Synchronises and debounces the three lane buttons and judges each press
// against the hit window. It retires hit notes through clear_req, tracks
// per-slot misses, and keeps a saturating score and streak.
// Lane mapping: btn[2]/pulse[2] = red (slots 0-4), [1] = green (5-9),
// [0] = blue (10-14).
// Optional feature: define JUDGE_PENALTY_EN to penalise a press that has no
// candidate note (score decremented, streak cleared). Without the macro such
// a press is ignored.
module note_hit_judge #(
    parameter int HIT_LO    = 410,
    parameter int HIT_HI    = 450,
    parameter int DB_CYCLES = 16,
    parameter int SCORE_HIT = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [2:0]   btn,
    input  logic [149:0] note_pos,
    input  logic [14:0]  note_active,
    output logic [14:0]  clear_req,
    output logic [2:0]   hit_pulse,
    output logic [2:0]   miss_pulse,
    output logic [7:0]   score,
    output logic [7:0]   streak
);

    localparam int              CW      = $clog2(DB_CYCLES + 1);
    localparam logic [9:0]      WIN_LO  = 10'(HIT_LO);
    localparam logic [9:0]      WIN_HI  = 10'(HIT_HI);
    localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        JUDGE = 2'd1,
        HELD  = 2'd2
    } lane_state_t;

    // Number of set bits in a three-lane vector.
    function automatic logic [1:0] pop3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // Reset synchroniser and input path
    logic            rst_meta_q;
    logic            rst_n_q;
    logic [2:0]      btn_s1_q;
    logic [2:0]      btn_s2_q;
    logic [CW-1:0]   db_cnt_q [3];
    logic [CW-1:0]   db_cnt_d [3];
    logic [2:0]      db_level_q;
    logic [2:0]      db_level_d;
    logic [2:0]      press_q;
    logic [2:0]      press_d;

    // Lane FSMs
    lane_state_t     state_q [3];
    lane_state_t     state_d [3];

    // Per-slot decode and miss tracking
    logic [14:0]     in_win;
    logic [14:0]     past_win;
    logic [14:0]     wrapped;
    logic [14:0]     armed_q;
    logic [14:0]     armed_d;
    logic [149:0]    pos_prev_q;
    logic [14:0]     hit_slot;
    logic [14:0]     miss_slot;
    logic [4:0]      lane_cand;
`ifdef JUDGE_PENALTY_EN
    logic [2:0]      empty_lane;
    logic [1:0]      ne;
`endif

    // Registered outputs and counters
    logic [14:0]     clear_req_q;
    logic [14:0]     clear_req_d;
    logic [2:0]      hit_pulse_q;
    logic [2:0]      hit_pulse_d;
    logic [2:0]      miss_pulse_q;
    logic [2:0]      miss_pulse_d;
    logic [7:0]      score_q;
    logic [7:0]      score_d;
    logic [7:0]      streak_q;
    logic [7:0]      streak_d;
    logic [1:0]      nh;
    logic [1:0]      nm;
    logic [11:0]     score_sum;
    logic [8:0]      streak_sum;

    // Reset assertion reaches all logic at once; release is aligned to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // Debounce: the level flips after DB_CYCLES differing samples in a row.
    always_comb begin
        press_d    = '0;
        db_level_d = db_level_q;
        for (int b = 0; b < 3; b++) begin
            db_cnt_d[b] = db_cnt_q[b];
            if (btn_s2_q[b] == db_level_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (db_cnt_q[b] == DB_LAST) begin
                db_cnt_d[b]   = '0;
                db_level_d[b] = ~db_level_q[b];
                press_d[b]    = ~db_level_q[b];
            end else begin
                db_cnt_d[b] = db_cnt_q[b] + CW'(1);
            end
        end
    end

    // Two-flop button synchroniser, debounce counters and press register.
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            db_level_q <= '0;
            press_q    <= '0;
            for (int b = 0; b < 3; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            btn_s1_q   <= btn;
            btn_s2_q   <= btn_s1_q;
            db_level_q <= db_level_d;
            press_q    <= press_d;
            for (int b = 0; b < 3; b++) begin
                db_cnt_q[b] <= db_cnt_d[b];
            end
        end
    end

    // Lane FSM next state: one JUDGE cycle per press, then wait for release.
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            state_d[b] = state_q[b];
            case (state_q[b])
                IDLE:    if (press_q[b]) state_d[b] = JUDGE;
                JUDGE:   state_d[b] = HELD;
                HELD:    if (!db_level_q[b]) state_d[b] = IDLE;
                default: state_d[b] = IDLE;
            endcase
        end
    end

    // Lane FSM state registers.
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            for (int b = 0; b < 3; b++) begin
                state_q[b] <= IDLE;
            end
        end else begin
            for (int b = 0; b < 3; b++) begin
                state_q[b] <= state_d[b];
            end
        end
    end

    // Per-slot window decode; a drop below the previous position is a wrap.
    always_comb begin
        in_win   = '0;
        past_win = '0;
        wrapped  = '0;
        for (int i = 0; i < 15; i++) begin
            in_win[i]   = (note_pos[10*i +: 10] >= WIN_LO) &&
                          (note_pos[10*i +: 10] <= WIN_HI);
            past_win[i] = (note_pos[10*i +: 10] > WIN_HI);
            wrapped[i]  = (note_pos[10*i +: 10] < pos_prev_q[10*i +: 10]);
        end
    end

    // Judge: in a lane's JUDGE cycle the lowest in-window active slot wins.
    always_comb begin
        hit_slot    = '0;
        hit_pulse_d = '0;
        lane_cand   = '0;
`ifdef JUDGE_PENALTY_EN
        empty_lane  = '0;
`endif
        for (int b = 0; b < 3; b++) begin
            if (state_q[b] == JUDGE) begin
                lane_cand = note_active[(2-b)*5 +: 5] & in_win[(2-b)*5 +: 5];
                hit_slot[(2-b)*5 +: 5] = lane_cand & (~lane_cand + 5'd1);
                hit_pulse_d[b] = |lane_cand;
`ifdef JUDGE_PENALTY_EN
                empty_lane[b]  = ~|lane_cand;
`endif
            end
        end
        clear_req_d = hit_slot;
    end

    // Miss tracking: an armed note that leaves the window unhit is a miss.
    always_comb begin
        miss_slot    = armed_q & note_active & ~hit_slot & (past_win | wrapped);
        miss_pulse_d = '0;
        for (int b = 0; b < 3; b++) begin
            miss_pulse_d[b] = |miss_slot[(2-b)*5 +: 5];
        end
        armed_d = armed_q;
        for (int i = 0; i < 15; i++) begin
            if (hit_slot[i] || miss_slot[i] || !note_active[i]) begin
                armed_d[i] = 1'b0;
            end else if (in_win[i]) begin
                armed_d[i] = 1'b1;
            end
        end
    end

    // Armed bits and the previous positions used for wrap detection.
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            armed_q    <= '0;
            pos_prev_q <= '0;
        end else begin
            armed_q    <= armed_d;
            pos_prev_q <= note_pos;
        end
    end

    // Score and streak follow the pulses being registered in the same edge.
    always_comb begin
        nh         = pop3(hit_pulse_d);
        nm         = pop3(miss_pulse_d);
        score_sum  = {4'b0000, score_q} + 12'(nh) * 12'(SCORE_HIT);
        score_d    = (score_sum > 12'd255) ? 8'd255 : score_sum[7:0];
        streak_sum = {1'b0, streak_q} + 9'(nh);
        if (nm != 2'd0) begin
            streak_d = 8'd0;
        end else begin
            streak_d = (streak_sum > 9'd255) ? 8'd255 : streak_sum[7:0];
        end
`ifdef JUDGE_PENALTY_EN
        ne = pop3(empty_lane);
        if (ne != 2'd0) begin
            score_d  = (score_d > 8'(ne)) ? (score_d - 8'(ne)) : 8'd0;
            streak_d = 8'd0;
        end
`endif
    end

    // Output pulse registers and the score/streak counters.
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            clear_req_q  <= '0;
            hit_pulse_q  <= '0;
            miss_pulse_q <= '0;
            score_q      <= '0;
            streak_q     <= '0;
        end else begin
            clear_req_q  <= clear_req_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            score_q      <= score_d;
            streak_q     <= streak_d;
        end
    end

    assign clear_req  = clear_req_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign score      = score_q;
    assign streak     = streak_q;

endmodule

// File: tb/tb_note_hit_judge.sv
// Directed testbench for note_hit_judge: reset, hit, bounce/hold, multi-lane,
// empty-press penalty, miss and wrap, saturation and reset during JUDGE.
module tb_note_hit_judge;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [2:0]   btn = '0;
    logic [149:0] note_pos = '0;
    logic [14:0]  note_active = '0;
    logic [14:0]  clear_req;
    logic [2:0]   hit_pulse;
    logic [2:0]   miss_pulse;
    logic [7:0]   score;
    logic [7:0]   streak;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_score = 0;
    int exp_streak = 0;

    int          hit_cnt;
    int          miss_cnt;
    logic [2:0]  hit_acc;
    logic [2:0]  miss_acc;
    logic [14:0] clear_acc;

    note_hit_judge dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn         (btn),
        .note_pos    (note_pos),
        .note_active (note_active),
        .clear_req   (clear_req),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .score       (score),
        .streak      (streak)
    );

    always #5 clk = ~clk;

    task automatic clr_stats();
        hit_cnt = 0; miss_cnt = 0; hit_acc = '0; miss_acc = '0; clear_acc = '0;
    endtask

    // One clock: sample just after the edge and act as the note generator.
    task automatic tick();
        @(posedge clk);
        #1;
        hit_cnt   += int'(hit_pulse[0]) + int'(hit_pulse[1]) + int'(hit_pulse[2]);
        miss_cnt  += int'(miss_pulse[0]) + int'(miss_pulse[1]) + int'(miss_pulse[2]);
        hit_acc   |= hit_pulse;
        miss_acc  |= miss_pulse;
        clear_acc |= clear_req;
        for (int i = 0; i < 15; i++) begin
            if (clear_req[i]) begin
                note_active[i] = 1'b0;
                note_pos[10*i +: 10] = '0;
            end
        end
    endtask

    task automatic set_note(input int slot, input int pos, input logic act);
        note_pos[10*slot +: 10] = 10'(pos);
        note_active[slot] = act;
    endtask

    task automatic settle();
        btn = '0;
        repeat (25) tick();
        clr_stats();
    endtask

    task automatic multi_press(output bit seen);
        int k;
        seen = 1'b0;
        set_note(1, 415, 1'b1); set_note(6, 415, 1'b1); set_note(11, 415, 1'b1);
        btn = 3'b111;
        k = 0;
        while (!seen && k < 30) begin
            tick();
            if (hit_pulse == 3'b111) seen = 1'b1;
            k++;
        end
        settle();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (score !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_score: got %0d expected 0", score); end
        n_cmp++; if (streak !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_streak: got %0d expected 0", streak); end
        n_cmp++; if (clear_req !== 15'd0) begin n_bad++; $display("[TB] FAIL reset_clear: got %h expected 0", clear_req); end
        n_cmp++; if ({hit_pulse, miss_pulse} !== 6'd0) begin n_bad++; $display("[TB] FAIL reset_pulses: got %b expected 0", {hit_pulse, miss_pulse}); end
        reset_n = 1'b1;
        repeat (5) tick();
        clr_stats();
    endtask

    task automatic test_empty_zero();
        btn[2] = 1'b1;
        repeat (25) tick();
        n_cmp++; if (score !== 8'(exp_score)) begin n_bad++; $display("[TB] FAIL empty_zero_score: got %0d expected %0d", score, exp_score); end
        n_cmp++; if (hit_cnt !== 0) begin n_bad++; $display("[TB] FAIL empty_zero_hits: got %0d expected 0", hit_cnt); end
        settle();
    endtask

    task automatic test_hit();
        set_note(0, 430, 1'b1);
        set_note(3, 440, 1'b1);
        btn[2] = 1'b1;
        repeat (19) tick();
        n_cmp++; if (hit_cnt !== 0) begin n_bad++; $display("[TB] FAIL hit_early: got %0d hits expected 0", hit_cnt); end
        tick();
        exp_score = 1; exp_streak = 1;
        n_cmp++; if (hit_pulse !== 3'b100) begin n_bad++; $display("[TB] FAIL hit_pulse: got %b expected 100", hit_pulse); end
        n_cmp++; if (clear_req !== 15'h0001) begin n_bad++; $display("[TB] FAIL hit_clear: got %h expected 0001", clear_req); end
        n_cmp++; if (score !== 8'(exp_score)) begin n_bad++; $display("[TB] FAIL hit_score: got %0d expected %0d", score, exp_score); end
        n_cmp++; if (streak !== 8'(exp_streak)) begin n_bad++; $display("[TB] FAIL hit_streak: got %0d expected %0d", streak, exp_streak); end
        tick();
        n_cmp++; if ({clear_req, hit_pulse} !== 18'd0) begin n_bad++; $display("[TB] FAIL hit_one_cycle: got %h expected 0", {clear_req, hit_pulse}); end
        set_note(3, 0, 1'b0);
        settle();
    endtask

    task automatic test_bounce_hold();
        set_note(5, 420, 1'b1);
        for (int k = 0; k < 8; k++) begin
            btn[1] = ~btn[1];
            repeat (5) tick();
        end
        n_cmp++; if (hit_cnt !== 0) begin n_bad++; $display("[TB] FAIL bounce_hits: got %0d expected 0", hit_cnt); end
        btn[1] = 1'b1;
        repeat (40) tick();
        exp_score += 1; exp_streak += 1;
        n_cmp++; if (hit_cnt !== 1 || hit_acc !== 3'b010) begin n_bad++; $display("[TB] FAIL stable_hit: got %0d hits mask %b expected 1 mask 010", hit_cnt, hit_acc); end
        n_cmp++; if (clear_acc !== 15'h0020) begin n_bad++; $display("[TB] FAIL stable_clear: got %h expected 0020", clear_acc); end
        n_cmp++; if (score !== 8'(exp_score)) begin n_bad++; $display("[TB] FAIL stable_score: got %0d expected %0d", score, exp_score); end
        set_note(5, 420, 1'b1);
        clr_stats();
        repeat (1000) tick();
        n_cmp++; if (hit_cnt !== 0 || clear_acc !== 15'd0) begin n_bad++; $display("[TB] FAIL hold_retrigger: got %0d hits clear %h expected 0", hit_cnt, clear_acc); end
        set_note(5, 0, 1'b0);
        settle();
    endtask

    task automatic test_multi_lane();
        set_note(1, 415, 1'b1); set_note(6, 415, 1'b1); set_note(11, 415, 1'b1);
        btn = 3'b111;
        repeat (20) tick();
        exp_score += 3; exp_streak += 3;
        n_cmp++; if (hit_pulse !== 3'b111) begin n_bad++; $display("[TB] FAIL multi_pulse: got %b expected 111", hit_pulse); end
        n_cmp++; if (clear_req !== 15'h0842) begin n_bad++; $display("[TB] FAIL multi_clear: got %h expected 0842", clear_req); end
        n_cmp++; if (score !== 8'(exp_score) || streak !== 8'(exp_streak)) begin n_bad++; $display("[TB] FAIL multi_score: got %0d/%0d expected %0d/%0d", score, streak, exp_score, exp_streak); end
        settle();
    endtask

    task automatic test_penalty();
        btn[1] = 1'b1;
        repeat (22) tick();
`ifdef JUDGE_PENALTY_EN
        exp_score = (exp_score > 0) ? exp_score - 1 : 0;
        exp_streak = 0;
`endif
        n_cmp++; if (score !== 8'(exp_score)) begin n_bad++; $display("[TB] FAIL penalty_score: got %0d expected %0d", score, exp_score); end
        n_cmp++; if (streak !== 8'(exp_streak)) begin n_bad++; $display("[TB] FAIL penalty_streak: got %0d expected %0d", streak, exp_streak); end
        settle();
    endtask

    task automatic test_miss();
        set_note(2, 430, 1'b1);
        btn[2] = 1'b1;
        repeat (22) tick();
        exp_score += 1; exp_streak += 1;
        n_cmp++; if (score !== 8'(exp_score) || streak !== 8'(exp_streak)) begin n_bad++; $display("[TB] FAIL pre_miss_hit: got %0d/%0d expected %0d/%0d", score, streak, exp_score, exp_streak); end
        settle();
        set_note(12, 440, 1'b1);
        repeat (2) tick();
        set_note(12, 451, 1'b1);
        tick();
        exp_streak = 0;
        n_cmp++; if (miss_pulse !== 3'b001) begin n_bad++; $display("[TB] FAIL miss_pulse: got %b expected 001", miss_pulse); end
        n_cmp++; if (streak !== 8'(exp_streak) || score !== 8'(exp_score)) begin n_bad++; $display("[TB] FAIL miss_counts: got %0d/%0d expected %0d/%0d", score, streak, exp_score, exp_streak); end
        repeat (5) tick();
        n_cmp++; if (miss_cnt !== 1 || clear_acc !== 15'd0) begin n_bad++; $display("[TB] FAIL miss_once: got %0d misses clear %h expected 1 and 0", miss_cnt, clear_acc); end
        set_note(12, 0, 1'b0);
        set_note(7, 445, 1'b1);
        repeat (2) tick();
        set_note(7, 0, 1'b1);
        tick();
        n_cmp++; if (miss_pulse !== 3'b010) begin n_bad++; $display("[TB] FAIL wrap_miss: got %b expected 010", miss_pulse); end
        set_note(7, 0, 1'b0);
        settle();
    endtask

    task automatic test_saturation();
        bit seen;
        for (int k = 0; k < 100 && exp_score < 255; k++) begin
            multi_press(seen);
            n_cmp++;
            if (!seen) begin
                n_bad++;
                $display("[TB] FAIL sat_press_timeout: got no hit expected 111 at press %0d", k);
                break;
            end
            exp_score = (exp_score + 3 > 255) ? 255 : exp_score + 3;
            exp_streak = (exp_streak + 3 > 255) ? 255 : exp_streak + 3;
        end
        n_cmp++; if (score !== 8'(exp_score)) begin n_bad++; $display("[TB] FAIL sat_reach: got %0d expected %0d", score, exp_score); end
        multi_press(seen);
        exp_streak = (exp_streak + 3 > 255) ? 255 : exp_streak + 3;
        n_cmp++; if (score !== 8'd255) begin n_bad++; $display("[TB] FAIL sat_score: got %0d expected 255", score); end
        n_cmp++; if (streak !== 8'(exp_streak)) begin n_bad++; $display("[TB] FAIL sat_streak: got %0d expected %0d", streak, exp_streak); end
    endtask

    task automatic test_reset_mid_judge();
        set_note(0, 430, 1'b1);
        btn[2] = 1'b1;
        repeat (19) tick();
        reset_n = 1'b0;
        #1;
        n_cmp++; if (score !== 8'd0 || streak !== 8'd0) begin n_bad++; $display("[TB] FAIL midreset_counts: got %0d/%0d expected 0/0", score, streak); end
        n_cmp++; if ({clear_req, hit_pulse, miss_pulse} !== 21'd0) begin n_bad++; $display("[TB] FAIL midreset_outputs: got %h expected 0", {clear_req, hit_pulse, miss_pulse}); end
        btn = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        clr_stats();
        repeat (30) tick();
        n_cmp++; if (hit_cnt !== 0 || score !== 8'd0) begin n_bad++; $display("[TB] FAIL midreset_after: got %0d hits score %0d expected 0/0", hit_cnt, score); end
    endtask

    initial begin
        clr_stats();
        test_reset();
        test_empty_zero();
        test_hit();
        test_bounce_hold();
        test_multi_lane();
        test_penalty();
        test_miss();
        test_saturation();
        test_reset_mid_judge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
